// File: rtl/gpu_pkg.sv
// Shared definitions for the thread datapath: LSU opcodes, LSU FSM states and
// register-file geometry.
package gpu_pkg;

    localparam int NUM_GPRS   = 13;
    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'b01,
        STORE = 2'b10
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WB   = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    // Registers at or above NUM_GPRS are read-only specials.
    function automatic logic is_gpr(input logic [REG_ADDR_W-1:0] rd);
        return (rd < REG_ADDR_W'(NUM_GPRS));
    endfunction

endpackage

// File: rtl/thread_lsu_if.sv
// Memory-controller side of the thread LSU: separate read and write
// valid/ready channels.
interface thread_lsu_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_read_valid;
    logic [ADDR_W-1:0] mem_read_addr;
    logic              mem_read_ready;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_write_valid;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_addr,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_addr, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_addr,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_addr, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/thread_lsu_timeout_ctr.sv
// Counts cycles spent waiting on memory; flags the last allowed cycle.
// TIMEOUT of 0 disables expiry entirely.
module lsu_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    // Wait-cycle counter, cleared whenever the LSU is not requesting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            logic w_unused_count;
            assign w_unused_count = &{1'b0, r_count};
            assign o_expire = 1'b0;
        end else begin : g_timeout
            assign o_expire = (r_count == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: takes RS1/RS2 from the register file, runs one
// memory transaction and writes load data back to the register file.
module thread_lsu
    import gpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [1:0]            issue_op,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [DATA_W-1:0]     rs1,
    input  logic [DATA_W-1:0]     rs2,
    thread_lsu_if.master          mem,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  done,
    output logic                  err
);

    lsu_state_t            r_state,    w_state_nx;
    logic                  r_is_load,  w_is_load_nx;
    logic [REG_ADDR_W-1:0] r_rd,       w_rd_nx;
    logic [ADDR_W-1:0]     r_addr,     w_addr_nx;
    logic [DATA_W-1:0]     r_data,     w_data_nx;
    logic                  r_rd_valid, w_rd_valid_nx;
    logic                  r_wr_valid, w_wr_valid_nx;
    logic                  r_wb_we,    w_wb_we_nx;
    logic [REG_ADDR_W-1:0] r_wb_addr,  w_wb_addr_nx;
    logic [DATA_W-1:0]     r_wb_data,  w_wb_data_nx;
    logic                  r_done,     w_done_nx;
    logic                  r_err,      w_err_nx;

    logic w_issue_ready;
    logic w_mem_ready;
    logic w_expire;
    logic w_unused_rs1_hi;

    // Only the low ADDR_W bits of RS1 form the address.
    assign w_unused_rs1_hi = &{1'b0, rs1[DATA_W-1:ADDR_W]};

    assign w_issue_ready = (r_state == IDLE) && enable;
    assign w_mem_ready   = r_is_load ? mem.mem_read_ready : mem.mem_write_ready;

    lsu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (r_state != REQ),
        .i_inc    ((r_state == REQ) && !w_mem_ready),
        .o_expire (w_expire)
    );

    // Next-state and next-output logic; outputs are registered from these
    // values so each pulse lines up with the state it belongs to.
    always_comb begin
        w_state_nx    = r_state;
        w_is_load_nx  = r_is_load;
        w_rd_nx       = r_rd;
        w_addr_nx     = r_addr;
        w_data_nx     = r_data;
        w_rd_valid_nx = r_rd_valid;
        w_wr_valid_nx = r_wr_valid;
        w_wb_we_nx    = 1'b0;
        w_wb_addr_nx  = r_wb_addr;
        w_wb_data_nx  = r_wb_data;
        w_done_nx     = 1'b0;
        w_err_nx      = 1'b0;

        case (r_state)
            IDLE: begin
                if (issue_valid && w_issue_ready) begin
                    w_rd_nx   = issue_rd;
                    w_addr_nx = rs1[ADDR_W-1:0];
                    w_data_nx = rs2;
                    case (issue_op)
                        LOAD: begin
                            w_is_load_nx  = 1'b1;
                            w_rd_valid_nx = 1'b1;
                            w_state_nx    = REQ;
                        end
                        STORE: begin
                            w_is_load_nx  = 1'b0;
                            w_wr_valid_nx = 1'b1;
                            w_state_nx    = REQ;
                        end
                        default: begin
                            w_is_load_nx = 1'b0;
                            w_done_nx    = 1'b1;
                            w_err_nx     = 1'b1;
                            w_state_nx   = DONE;
                        end
                    endcase
                end else begin
                    w_state_nx = IDLE;
                end
            end
            REQ: begin
                if (w_mem_ready) begin
                    w_rd_valid_nx = 1'b0;
                    w_wr_valid_nx = 1'b0;
                    if (r_is_load) begin
                        w_wb_data_nx = mem.mem_read_data;
                        w_wb_addr_nx = r_rd;
                        w_wb_we_nx   = is_gpr(r_rd);
                        w_state_nx   = WB;
                    end else begin
                        w_done_nx  = 1'b1;
                        w_state_nx = DONE;
                    end
                end else if (w_expire) begin
                    // Ready on the expiry cycle is handled above and wins.
                    w_rd_valid_nx = 1'b0;
                    w_wr_valid_nx = 1'b0;
                    w_done_nx     = 1'b1;
                    w_err_nx      = 1'b1;
                    w_state_nx    = DONE;
                end else begin
                    w_state_nx = REQ;
                end
            end
            WB: begin
                w_done_nx  = 1'b1;
                w_state_nx = DONE;
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_rd_valid_nx = 1'b0;
                w_wr_valid_nx = 1'b0;
                w_state_nx    = IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_is_load  <= 1'b0;
            r_rd       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rd_valid <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_is_load  <= w_is_load_nx;
            r_rd       <= w_rd_nx;
            r_addr     <= w_addr_nx;
            r_data     <= w_data_nx;
            r_rd_valid <= w_rd_valid_nx;
            r_wr_valid <= w_wr_valid_nx;
            r_wb_we    <= w_wb_we_nx;
            r_wb_addr  <= w_wb_addr_nx;
            r_wb_data  <= w_wb_data_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
        end
    end

    assign issue_ready         = w_issue_ready;
    assign mem.mem_read_valid  = r_rd_valid;
    assign mem.mem_read_addr   = r_addr;
    assign mem.mem_write_valid = r_wr_valid;
    assign mem.mem_write_addr  = r_addr;
    assign mem.mem_write_data  = r_data;
    assign wb_we               = r_wb_we;
    assign wb_addr             = r_wb_addr;
    assign wb_data             = r_wb_data;
    assign done                = r_done;
    assign err                 = r_err;

endmodule

// File: tb/tb_thread_lsu.sv
// Self-checking bench for thread_lsu: transaction-level model predicting each
// cycle's outputs from issue time and chosen memory latency.
module tb_thread_lsu;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          issue_valid = 1'b0;
    logic [1:0]    issue_op = 2'b00;
    logic [3:0]    issue_rd = 4'd0;
    logic [DW-1:0] rs1 = '0;
    logic [DW-1:0] rs2 = '0;
    wire           issue_ready;
    wire           wb_we;
    wire  [3:0]    wb_addr;
    wire  [DW-1:0] wb_data;
    wire           done;
    wire           err;

    thread_lsu_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    thread_lsu #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .mem         (mem_if.master),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Current transaction: kind 0=load 1=store 2=illegal, d = wait cycles before ready
    bit            have = 1'b0;
    int            m_t0, m_kind, m_n, m_d, m_end;
    bit            m_tout;
    logic [3:0]    m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_sdata, m_ldata;

    // Observations collected by the checker for the directed literal checks
    int            rv_cnt = 0, wv_cnt = 0, wb_cnt = 0, done_cnt = 0;
    int            last_wb_cyc = 0, last_done_cyc = 0;
    logic          last_err = 1'b0;
    logic [3:0]    last_wb_addr = '0;
    logic [DW-1:0] last_wb_data = '0, last_wdata = '0;
    logic [AW-1:0] last_raddr = '0, last_waddr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit inflight(input int c);
        return have && (c > m_t0) && (c <= m_end);
    endfunction

    // One clock of stimulus: presents the issue inputs and plays the memory.
    task automatic cycle(input bit iv, input bit en, input logic [1:0] op, input logic [3:0] rd,
                         input logic [DW-1:0] a, input logic [DW-1:0] sd,
                         input logic [DW-1:0] ld, input int d);
        int c;
        bit in_req, sched;
        @(posedge clk);
        #1;
        c = cyc;
        enable = en; issue_valid = iv; issue_op = op; issue_rd = rd; rs1 = a; rs2 = sd;
        if (!inflight(c) && en && iv) begin
            have    = 1'b1;
            m_t0    = c;
            m_kind  = (op == 2'b01) ? 0 : (op == 2'b10) ? 1 : 2;
            m_rd    = rd;
            m_addr  = a[AW-1:0];
            m_sdata = sd;
            m_ldata = ld;
            m_d     = d;
            m_tout  = (m_kind != 2) && (d + 1 > TO);
            m_n     = (m_kind == 2) ? 0 : (m_tout ? TO : d + 1);
            if (m_kind == 2)                m_end = c + 1;
            else if (m_kind == 0 && !m_tout) m_end = c + m_n + 2;
            else                             m_end = c + m_n + 1;
        end
        in_req = have && (m_kind != 2) && (c > m_t0) && (c <= m_t0 + m_n);
        sched  = in_req && (c == m_t0 + 1 + m_d);
        if (in_req && m_kind == 0) begin
            mem_if.mem_read_ready = sched;
            mem_if.mem_read_data  = sched ? m_ldata : DW'($urandom);
        end else begin
            mem_if.mem_read_ready = 1'($urandom % 2);
            mem_if.mem_read_data  = DW'($urandom);
        end
        if (in_req && m_kind == 1) mem_if.mem_write_ready = sched;
        else                       mem_if.mem_write_ready = 1'($urandom % 2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 2'b00, 4'd0, '0, '0, '0, 0);
    endtask

    // Compare process: every cycle, DUT outputs against the model's prediction.
    always @(negedge clk) begin : compare_p
        int c;
        bit rv, wv, we, dn, er;
        if (chk_en) begin
            c  = cyc;
            rv = have && m_kind == 0 && c > m_t0 && c <= m_t0 + m_n;
            wv = have && m_kind == 1 && c > m_t0 && c <= m_t0 + m_n;
            we = have && m_kind == 0 && !m_tout && m_rd < 4'd13 && c == m_t0 + m_n + 1;
            dn = have && c == m_end;
            er = dn && (m_kind == 2 || m_tout);
            chk("issue_ready", issue_ready, !inflight(c) && enable);
            chk("mem_read_valid", mem_if.mem_read_valid, rv);
            chk("mem_write_valid", mem_if.mem_write_valid, wv);
            chk("wb_we", wb_we, we);
            chk("done", done, dn);
            chk("err", err, er);
            if (rv) chk("mem_read_addr", mem_if.mem_read_addr, m_addr);
            if (wv) begin
                chk("mem_write_addr", mem_if.mem_write_addr, m_addr);
                chk("mem_write_data", mem_if.mem_write_data, m_sdata);
            end
            if (we) begin
                chk("wb_addr", wb_addr, m_rd);
                chk("wb_data", wb_data, m_ldata);
            end
        end
        if (mem_if.mem_read_valid)  begin rv_cnt++; last_raddr = mem_if.mem_read_addr; end
        if (mem_if.mem_write_valid) begin
            wv_cnt++; last_waddr = mem_if.mem_write_addr; last_wdata = mem_if.mem_write_data;
        end
        if (wb_we) begin wb_cnt++; last_wb_cyc = cyc; last_wb_addr = wb_addr; last_wb_data = wb_data; end
        if (done)  begin done_cnt++; last_done_cyc = cyc; last_err = err; end
    end

    int rv0, wv0, wb0, dn0, t;

    task automatic snap();
        rv0 = rv_cnt; wv0 = wv_cnt; wb0 = wb_cnt; dn0 = done_cnt;
    endtask

    initial begin
        mem_if.mem_read_ready = 1'b0; mem_if.mem_write_ready = 1'b0; mem_if.mem_read_data = '0;
        #12;
        chk("rst issue_ready en0", issue_ready, 1'b0);
        chk("rst read_valid", mem_if.mem_read_valid, 1'b0);
        chk("rst write_valid", mem_if.mem_write_valid, 1'b0);
        chk("rst wb_we", wb_we, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst read_addr", mem_if.mem_read_addr, 8'h00);
        chk("rst wb_data", wb_data, 16'h0000);
        enable = 1'b1;
        #1 chk("rst issue_ready en1", issue_ready, 1'b1);
        #4 reset = 1'b0;
        chk_en = 1'b1;

        // LOAD, ready two cycles after valid rises
        snap();
        cycle(1'b1, 1'b1, 2'b01, 4'd3, 16'h0042, 16'h0000, 16'hBEEF, 2);
        t = m_t0; idle(8);
        chk("ld valid cycles", rv_cnt - rv0, 3);
        chk("ld addr", last_raddr, 8'h42);
        chk("ld wb count", wb_cnt - wb0, 1);
        chk("ld wb time", last_wb_cyc - t, 4);
        chk("ld wb addr", last_wb_addr, 4'd3);
        chk("ld wb data", last_wb_data, 16'hBEEF);
        chk("ld done time", last_done_cyc - t, 5);
        chk("ld err", last_err, 1'b0);

        // STORE, ready on first valid cycle
        snap();
        cycle(1'b1, 1'b1, 2'b10, 4'd5, 16'h0010, 16'h1234, 16'h0000, 0);
        t = m_t0; idle(6);
        chk("st valid cycles", wv_cnt - wv0, 1);
        chk("st addr", last_waddr, 8'h10);
        chk("st data", last_wdata, 16'h1234);
        chk("st done time", last_done_cyc - t, 2);
        chk("st no wb", wb_cnt - wb0, 0);

        // LOAD to special register: no writeback, no error
        snap();
        cycle(1'b1, 1'b1, 2'b01, 4'd14, 16'h0077, 16'h0000, 16'h5A5A, 1);
        t = m_t0; idle(6);
        chk("rd14 no wb", wb_cnt - wb0, 0);
        chk("rd14 done time", last_done_cyc - t, 4);
        chk("rd14 err", last_err, 1'b0);

        // LOAD that never sees ready: timeout
        snap();
        cycle(1'b1, 1'b1, 2'b01, 4'd2, 16'h0033, 16'h0000, 16'h0000, 100);
        t = m_t0; idle(8);
        chk("to valid cycles", rv_cnt - rv0, 4);
        chk("to done time", last_done_cyc - t, 5);
        chk("to err", last_err, 1'b1);
        chk("to no wb", wb_cnt - wb0, 0);

        // STORE with ready exactly on the expiry cycle
        snap();
        cycle(1'b1, 1'b1, 2'b10, 4'd0, 16'h0021, 16'hCAFE, 16'h0000, 3);
        t = m_t0; idle(8);
        chk("edge valid cycles", wv_cnt - wv0, 4);
        chk("edge done time", last_done_cyc - t, 5);
        chk("edge err", last_err, 1'b0);

        // Illegal opcode
        snap();
        cycle(1'b1, 1'b1, 2'b11, 4'd1, 16'h0001, 16'h0000, 16'h0000, 0);
        t = m_t0; idle(2);
        chk("ill issue_ready T+2", issue_ready, 1'b1);
        idle(3);
        chk("ill done time", last_done_cyc - t, 1);
        chk("ill err", last_err, 1'b1);
        chk("ill no mem", (rv_cnt - rv0) + (wv_cnt - wv0), 0);

        // Reset in the middle of a LOAD request
        cycle(1'b1, 1'b1, 2'b01, 4'd4, 16'h0099, 16'h0000, 16'h0000, 100);
        idle(2);
        chk_en = 1'b0;
        chk("pre-reset read_valid", mem_if.mem_read_valid, 1'b1);
        #2 reset = 1'b1;
        #1 chk("async drop read_valid", mem_if.mem_read_valid, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0; have = 1'b0; enable = 1'b1;
        #1 chk("post-reset issue_ready", issue_ready, 1'b1);
        chk_en = 1'b1;
        snap();
        cycle(1'b1, 1'b1, 2'b10, 4'd0, 16'h0055, 16'hA5A5, 16'h0000, 1);
        t = m_t0; idle(6);
        chk("post-reset st done", last_done_cyc - t, 3);
        chk("post-reset st data", last_wdata, 16'hA5A5);

        // Disabled thread ignores issue_valid
        snap();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 2'b01, 4'd1, 16'h0011, 16'h0000, 16'h0000, 0);
        chk("disabled issue_ready", issue_ready, 1'b0);
        idle(4);
        chk("disabled no op", (rv_cnt - rv0) + (done_cnt - dn0), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [1:0] op;
            r  = int'($urandom % 8);
            op = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (($urandom % 2) != 0 ? 2'b11 : 2'b00);
            cycle(($urandom % 3) == 0, ($urandom % 8) != 0, op, 4'($urandom),
                  DW'($urandom), DW'($urandom), DW'($urandom), int'($urandom % 6));
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
